// File: rtl/coriolis_ker0_add2.sv
// Two-input FP32 (flopoco format) stream adder with per-input alignment FIFOs,
// a LAT-stage stallable adder pipeline and a registered valid/ready output.
module coriolis_ker0_add2 #(
    parameter int unsigned STREAMW    = 34,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LAT        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivalid_in1_s0,
    input  logic [STREAMW-1:0] in1_s0,
    output logic               iready_in1,
    input  logic               ivalid_in2_s0,
    input  logic [STREAMW-1:0] in2_s0,
    output logic               iready_in2,
    output logic               ovalid,
    output logic [STREAMW-1:0] out1_s0,
    input  logic               oready
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    // flopoco FPAdd 8/23: {exn[1:0], sign, exp[7:0], frac[22:0]}, round-to-nearest-even.
    function automatic logic [33:0] fp_add(input logic [33:0] a, input logic [33:0] b);
        logic [1:0]  ea, eb;
        logic        sa, sb, sx, sy, found, inc;
        logic [7:0]  xe, ye, d;
        logic [22:0] xf, yf;
        logic [50:0] yw;
        logic [26:0] xa, ya, n;
        logic [27:0] sum;
        logic [4:0]  lz;
        logic [24:0] mr;
        int          e;
        logic [33:0] r;
        ea = a[33:32];
        eb = b[33:32];
        sa = a[31];
        sb = b[31];
        // Larger magnitude becomes X so only Y is ever shifted right.
        if (b[30:0] > a[30:0]) begin
            sx = sb; xe = b[30:23]; xf = b[22:0];
            sy = sa; ye = a[30:23]; yf = a[22:0];
        end else begin
            sx = sa; xe = a[30:23]; xf = a[22:0];
            sy = sb; ye = b[30:23]; yf = b[22:0];
        end
        d   = xe - ye;
        yw  = {1'b1, yf, 27'd0} >> d;
        ya  = (d > 8'd26) ? 27'd1 : {yw[50:25], |yw[24:0]};
        xa  = {1'b1, xf, 3'b000};
        sum = (sx != sy) ? ({1'b0, xa} - {1'b0, ya}) : ({1'b0, xa} + {1'b0, ya});
        lz    = '0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (sum[i]) found = 1'b1;
                else        lz = lz + 5'd1;
            end
        end
        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = int'(xe) + 1;
        end else begin
            n = sum[26:0] << lz;
            e = int'(xe) - int'(lz);
        end
        inc = n[2] & (n[3] | n[1] | n[0]);
        mr  = {1'b0, n[26:3]} + {24'd0, inc};
        if (mr[24]) e = e + 1;
        if (sum == 28'd0) begin
            r = 34'd0;
        end else if (e > 255) begin
            r = {2'b10, sx, 31'd0};
        end else if (e < 0) begin
            r = {2'b00, sx, 31'd0};
        end else begin
            r = {2'b01, sx, 8'(e), (mr[24] | ~mr[23]) ? 23'd0 : mr[22:0]};
        end
        if (ea == 2'b11 || eb == 2'b11) begin
            r = {2'b11, 32'd0};
        end else if (ea == 2'b10 && eb == 2'b10) begin
            r = (sa == sb) ? {2'b10, sa, 31'd0} : {2'b11, 32'd0};
        end else if (ea == 2'b10) begin
            r = {2'b10, sa, 31'd0};
        end else if (eb == 2'b10) begin
            r = {2'b10, sb, 31'd0};
        end else if (ea == 2'b00 && eb == 2'b00) begin
            r = {2'b00, sa & sb, 31'd0};
        end else if (ea == 2'b00) begin
            r = b;
        end else if (eb == 2'b00) begin
            r = a;
        end
        return r;
    endfunction

    // Alignment FIFOs; index 0 is operand 1, index 1 is operand 2.
    logic [STREAMW-1:0] mem_q  [2][FIFO_DEPTH];
    logic [STREAMW-1:0] mem_d  [2][FIFO_DEPTH];
    logic [AW-1:0]      wptr_q [2];
    logic [AW-1:0]      wptr_d [2];
    logic [AW-1:0]      rptr_q [2];
    logic [AW-1:0]      rptr_d [2];
    logic [CW-1:0]      cnt_q  [2];
    logic [CW-1:0]      cnt_d  [2];
    logic [STREAMW-1:0] idata  [2];
    logic [STREAMW-1:0] head   [2];
    logic [1:0]         ivalid, iready, push, empty;

    // Adder pipeline and output register.
    logic [LAT-1:0]     vld_q, vld_d;
    logic [STREAMW-1:0] core_q [LAT];
    logic [STREAMW-1:0] core_d [LAT];
    logic [STREAMW-1:0] sum_c;
    logic               ovalid_q, ovalid_d;
    logic [STREAMW-1:0] out_q, out_d;
    logic               adv, fire;

    assign idata[0] = in1_s0;
    assign idata[1] = in2_s0;
    assign ivalid   = {ivalid_in2_s0, ivalid_in1_s0};

    always_comb begin
        iready = '0;
        empty  = '0;
        push   = '0;
        for (int i = 0; i < 2; i++) begin
            iready[i] = (cnt_q[i] != CW'(FIFO_DEPTH));
            empty[i]  = (cnt_q[i] == '0);
            push[i]   = ivalid[i] & iready[i];
            head[i]   = mem_q[i][rptr_q[i]];
        end
    end

    assign adv   = ~(ovalid_q & ~oready);
    assign fire  = adv & ~empty[0] & ~empty[1];
    assign sum_c = fp_add(head[0], head[1]);

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_d[i][wptr_q[i]] = idata[i];
                wptr_d[i]           = wptr_q[i] + AW'(1);
            end
            if (fire) rptr_d[i] = rptr_q[i] + AW'(1);
            case ({push[i], fire})
                2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Everything downstream of the FIFOs freezes together while the output is blocked.
    always_comb begin
        vld_d    = vld_q;
        core_d   = core_q;
        ovalid_d = ovalid_q;
        out_d    = out_q;
        if (adv) begin
            vld_d[0]  = fire;
            core_d[0] = sum_c;
            for (int i = 1; i < LAT; i++) begin
                vld_d[i]  = vld_q[i-1];
                core_d[i] = core_q[i-1];
            end
            ovalid_d = vld_q[LAT-1];
            out_d    = core_q[LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '{default: '0};
            rptr_q   <= '{default: '0};
            cnt_q    <= '{default: '0};
            vld_q    <= '0;
            core_q   <= '{default: '0};
            ovalid_q <= 1'b0;
            out_q    <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            core_q   <= core_d;
            ovalid_q <= ovalid_d;
            out_q    <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign iready_in1 = iready[0];
    assign iready_in2 = iready[1];
    assign ovalid     = ovalid_q;
    assign out1_s0    = out_q;

endmodule
